stopwatch_display: RTL and testbench
====================================

Name: stopwatch_display

Overview:
- Downstream of the stopwatch counter; drives the board's 4-digit common-anode seven-segment display.
- Consumes the four BCD digits (sec_1s, sec_10s, min_1s, min_10s) and multiplexes them one digit at a time.
- Latches a coherent frame of digits once per scan so the display never tears mid-scan.
- In adjust mode, blinks the selected digit pair: minutes when sel=0, seconds when sel=1.

Parameters:
REFRESH_CNT, 50000, clk cycles each digit is driven (100 MHz -> 500 us per digit)
BLINK_CNT, 25000000, clk cycles per blink half-period (100 MHz -> 0.25 s)

Ports:
clk  in  1  system clock, single clock domain
rst  in  1  reset, asynchronous, active-low (0 = reset)
sec_1s_in  in  4  BCD seconds units
sec_10s_in  in  4  BCD seconds tens
min_1s_in  in  4  BCD minutes units
min_10s_in  in  4  BCD minutes tens
adj  in  1  adjust mode active
sel  in  1  adjust select: 0 = minutes, 1 = seconds
an  out  4  digit anodes, active-low, one-hot-low when lit
seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low
dp  out  1  decimal point, active-low

Behaviour:
- Reset (rst=0, async):
  - an=4'b1111, seg=7'b1111111, dp=1.
  - Digit index idx=3; refresh and blink counters 0; blink_phase=0; frame latch 0.
- Refresh counter:
  - Counts 0..REFRESH_CNT-1, then wraps.
  - The tick is the cycle where count == REFRESH_CNT-1.
- On each tick edge, idx <= idx+1 (2-bit wrap). an, seg and dp are registered on that same edge from the new idx, so the outputs are always consistent with idx.
- After reset, outputs stay blank for REFRESH_CNT cycles. The first tick moves idx 3->0.
- Digit map (all on an active-low anode):
  - idx0: sec_1s on an[0].
  - idx1: sec_10s on an[1].
  - idx2: min_1s on an[2].
  - idx3: min_10s on an[3].
- Frame latch:
  - On the 3->0 tick edge, all four inputs are captured into shadow registers.
  - idx0 at that edge decodes sec_1s_in directly; this equals the captured value.
  - idx1..3 decode the shadow registers only.
  - Input changes mid-frame appear from the next frame on.
- Decode, BCD to active-low seg:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Codes 10..15 give 1111111 (blank segments); the anode is still driven.
- dp=0 only when idx=2 (minutes/seconds separator); otherwise 1. dp is not affected by blinking.
- Blink counter:
  - While adj=1: counts 0..BLINK_CNT-1 and toggles blink_phase at the terminal count.
  - While adj=0: counter and blink_phase are forced to 0 synchronously on every cycle.
- Blanking:
  - Applies at a tick edge if adj=1, blink_phase=1 and the new idx is in the selected pair (sel=1 -> idx0/1, sel=0 -> idx2/3).
  - A blanked digit gets an=4'b1111 and seg=1111111.
  - adj, sel and blink_phase are sampled only at tick edges, so a mode change takes effect within one refresh period.
- Reset mid-scan: immediate blank outputs. The sequence restarts as from power-up.

Decomposition:
- Shared package `stopwatch_pkg`:
  - SEG_0..SEG_9 and SEG_BLANK encodings.
  - Digit index constants IDX_SEC1, IDX_SEC10, IDX_MIN1, IDX_MIN10.
  - SEL_MIN=0, SEL_SEC=1.
- One combinational sub-module `seg7_decode` (4-bit BCD in, 7-bit active-low out) holds the table.
- The top module holds the counters, idx, frame latch, blink logic and output registers.

Test Plan:
All scenarios use REFRESH_CNT=4 and BLINK_CNT=16.
1. Reset: rst=0 -> an=1111, seg=1111111, dp=1. Release with digits min10=1, min1=2, sec10=3, sec1=4 -> an stays 1111 for 4 cycles, then an=1110, seg=0011001.
2. Scan order, same digits: each held 4 cycles:
   - an=1110 seg=0011001 dp=1
   - an=1101 seg=0110000 dp=1
   - an=1011 seg=0100100 dp=0
   - an=0111 seg=1111001 dp=1
   - then back to an=1110.
3. Frame latch: during idx0 change sec_10s_in 3->8 -> idx1 of the current frame shows 0110000; idx1 of the next frame shows 0000000.
4. Blink seconds: adj=1, sel=1 -> digits idx0/1 show an=1111 in alternate 16-cycle windows. idx2/3 are unaffected, and dp=0 at idx2 throughout.
5. Leave adjust while blanked: set adj=0 while blink_phase=1 -> blink_phase=0 the next cycle; idx0/1 are visible from the next tick.
6. Invalid BCD: sec_1s_in=4'hA -> at idx0 an=1110, seg=1111111. Assert rst mid-scan at idx2 -> outputs blank immediately; after release the first lit digit is idx0.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared encodings for the stopwatch display path.
// Active-low segment patterns {g,f,e,d,c,b,a}, digit indices and adjust-select values.
package stopwatch_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [1:0] IDX_SEC1  = 2'd0;
  localparam logic [1:0] IDX_SEC10 = 2'd1;
  localparam logic [1:0] IDX_MIN1  = 2'd2;
  localparam logic [1:0] IDX_MIN10 = 2'd3;

  localparam logic SEL_MIN = 1'b0;
  localparam logic SEL_SEC = 1'b1;

  typedef struct packed {
    logic [3:0] sec_1s;
    logic [3:0] sec_10s;
    logic [3:0] min_1s;
    logic [3:0] min_10s;
  } digits_t;

  // Active-low one-hot anode for a digit index.
  function automatic logic [3:0] anode_of(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD to active-low seven-segment decoder; purely combinational.
// Zero latency, no flow control; codes 10..15 decode to all segments off.
module seg7_decode
  import stopwatch_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/stopwatch_display.sv
// Multiplexed 4-digit common-anode driver with per-scan frame latch and adjust-mode blinking.
// Outputs registered on each refresh tick; no backpressure, inputs are sampled freely.
module stopwatch_display
  import stopwatch_pkg::*;
#(
  parameter int REFRESH_CNT = 50000,
  parameter int BLINK_CNT   = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sec_1s_in,
  input  logic [3:0] sec_10s_in,
  input  logic [3:0] min_1s_in,
  input  logic [3:0] min_10s_in,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int RW = (REFRESH_CNT > 1) ? $clog2(REFRESH_CNT) : 1;
  localparam int BW = (BLINK_CNT > 1) ? $clog2(BLINK_CNT) : 1;

  logic [RW-1:0] refresh_cnt;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic [1:0]    idx;
  logic [1:0]    next_idx;
  logic          tick;
  digits_t       frame;
  logic [3:0]    digit;
  logic [6:0]    digit_seg;
  logic          in_sel_pair;
  logic          blank;

  assign tick     = (refresh_cnt == RW'(REFRESH_CNT - 1));
  assign next_idx = idx + 2'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refresh_cnt <= '0;
    end else if (tick) begin
      refresh_cnt <= '0;
    end else begin
      refresh_cnt <= refresh_cnt + RW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (!adj) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_CNT - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  // The whole frame is captured as the scan wraps to idx0, so digits 1..3 never tear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame <= '0;
    end else if (tick && (idx == IDX_MIN10)) begin
      frame.sec_1s  <= sec_1s_in;
      frame.sec_10s <= sec_10s_in;
      frame.min_1s  <= min_1s_in;
      frame.min_10s <= min_10s_in;
    end
  end

  // idx0 is decoded straight from the input on the same edge that latches it.
  always_comb begin
    digit = sec_1s_in;
    case (next_idx)
      IDX_SEC1:  digit = sec_1s_in;
      IDX_SEC10: digit = frame.sec_10s;
      IDX_MIN1:  digit = frame.min_1s;
      IDX_MIN10: digit = frame.min_10s;
      default:   digit = sec_1s_in;
    endcase
  end

  seg7_decode u_decode (
    .bcd (digit),
    .seg (digit_seg)
  );

  assign in_sel_pair = (sel == SEL_SEC) ? (next_idx == IDX_SEC1 || next_idx == IDX_SEC10)
                                        : (next_idx == IDX_MIN1 || next_idx == IDX_MIN10);
  assign blank       = adj && blink_phase && in_sel_pair;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx <= IDX_MIN10;
      an  <= 4'b1111;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else if (tick) begin
      idx <= next_idx;
      an  <= blank ? 4'b1111 : anode_of(next_idx);
      seg <= blank ? SEG_BLANK : digit_seg;
      dp  <= (next_idx != IDX_MIN1);
    end
  end

endmodule

// File: tb/tb_stopwatch_display.sv
// Directed, table-driven check of scan order, frame latch, blinking, invalid BCD and reset.
// Each table row applies inputs and advances to the next refresh tick before comparing.
module tb_stopwatch_display;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sec_1s_in, sec_10s_in, min_1s_in, min_10s_in;
  logic       adj, sel;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] SB = 7'b1111111;

  localparam logic [3:0] A0 = 4'b1110;
  localparam logic [3:0] A1 = 4'b1101;
  localparam logic [3:0] A2 = 4'b1011;
  localparam logic [3:0] A3 = 4'b0111;
  localparam logic [3:0] AB = 4'b1111;

  always #5 clk = ~clk;

  stopwatch_display #(.REFRESH_CNT(4), .BLINK_CNT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .sec_1s_in  (sec_1s_in),
    .sec_10s_in (sec_10s_in),
    .min_1s_in  (min_1s_in),
    .min_10s_in (min_10s_in),
    .adj        (adj),
    .sel        (sel),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  typedef struct {
    int         ncyc;
    logic [3:0] s1, s10, m1, m10;
    logic       adj, sel;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int n, logic [3:0] s1, logic [3:0] s10, logic a, logic s,
                              logic [3:0] ea, logic [6:0] es, logic ed);
    vec_t v;
    v.ncyc = n; v.s1 = s1; v.s10 = s10; v.m1 = 4'd2; v.m10 = 4'd1;
    v.adj = a; v.sel = s; v.e_an = ea; v.e_seg = es; v.e_dp = ed;
    return v;
  endfunction

  task automatic check(input string nm, input logic [6:0] act, input logic [6:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  task automatic check_out(input string nm, input logic [3:0] ea, input logic [6:0] es, input logic ed);
    check({nm, "_an"},  {3'b000, an}, {3'b000, ea});
    check({nm, "_seg"}, seg, es);
    check({nm, "_dp"},  {6'b0, dp}, {6'b0, ed});
  endtask

  initial begin
    // Frame latch: sec_10s changes after the capture edge.
    tbl.push_back(mk(1, 4, 3, 0, 0, A0, S4, 1));
    tbl.push_back(mk(4, 4, 3, 0, 0, A1, S3, 1));
    tbl.push_back(mk(4, 4, 3, 0, 0, A2, S2, 0));
    tbl.push_back(mk(4, 4, 3, 0, 0, A3, S1, 1));
    tbl.push_back(mk(4, 4, 3, 0, 0, A0, S4, 1));
    tbl.push_back(mk(4, 4, 8, 0, 0, A1, S3, 1));
    tbl.push_back(mk(4, 4, 8, 0, 0, A2, S2, 0));
    tbl.push_back(mk(4, 4, 8, 0, 0, A3, S1, 1));
    tbl.push_back(mk(4, 4, 8, 0, 0, A0, S4, 1));
    tbl.push_back(mk(4, 4, 8, 0, 0, A1, S8, 1));
    tbl.push_back(mk(4, 4, 8, 0, 0, A2, S2, 0));
    tbl.push_back(mk(4, 4, 8, 0, 0, A3, S1, 1));
    // Blink seconds: phase 1 covers the second frame after adj rises.
    tbl.push_back(mk(4, 4, 8, 1, 1, A0, S4, 1));
    tbl.push_back(mk(4, 4, 8, 1, 1, A1, S8, 1));
    tbl.push_back(mk(4, 4, 8, 1, 1, A2, S2, 0));
    tbl.push_back(mk(4, 4, 8, 1, 1, A3, S1, 1));
    tbl.push_back(mk(4, 4, 8, 1, 1, AB, SB, 1));
    tbl.push_back(mk(4, 4, 8, 1, 1, AB, SB, 1));
    tbl.push_back(mk(4, 4, 8, 1, 1, A2, S2, 0));
    tbl.push_back(mk(4, 4, 8, 1, 1, A3, S1, 1));
    tbl.push_back(mk(4, 4, 8, 1, 1, A0, S4, 1));
    tbl.push_back(mk(4, 4, 8, 1, 1, A1, S8, 1));
    tbl.push_back(mk(4, 4, 8, 1, 1, A2, S2, 0));
    tbl.push_back(mk(4, 4, 8, 1, 1, A3, S1, 1));
    tbl.push_back(mk(4, 4, 8, 1, 1, AB, SB, 1));
    // Leave adjust while blanked.
    tbl.push_back(mk(4, 4, 8, 0, 1, A1, S8, 1));
    tbl.push_back(mk(4, 4, 8, 0, 1, A2, S2, 0));
    tbl.push_back(mk(4, 4, 8, 0, 1, A3, S1, 1));
    // Blink minutes: dp stays low on a blanked idx2.
    tbl.push_back(mk(4, 4, 8, 1, 0, A0, S4, 1));
    tbl.push_back(mk(4, 4, 8, 1, 0, A1, S8, 1));
    tbl.push_back(mk(4, 4, 8, 1, 0, A2, S2, 0));
    tbl.push_back(mk(4, 4, 8, 1, 0, A3, S1, 1));
    tbl.push_back(mk(4, 4, 8, 1, 0, A0, S4, 1));
    tbl.push_back(mk(4, 4, 8, 1, 0, A1, S8, 1));
    tbl.push_back(mk(4, 4, 8, 1, 0, AB, SB, 0));
    tbl.push_back(mk(4, 4, 8, 1, 0, AB, SB, 1));
    tbl.push_back(mk(4, 4, 8, 0, 0, A0, S4, 1));
    tbl.push_back(mk(4, 4, 8, 0, 0, A1, S8, 1));
    tbl.push_back(mk(4, 4, 8, 0, 0, A2, S2, 0));
    tbl.push_back(mk(4, 4, 8, 0, 0, A3, S1, 1));
    // Invalid BCD on the directly decoded digit.
    tbl.push_back(mk(4, 4'hA, 8, 0, 0, A0, SB, 1));
    tbl.push_back(mk(4, 4'hA, 8, 0, 0, A1, S8, 1));
    tbl.push_back(mk(4, 4'hA, 8, 0, 0, A2, S2, 0));

    rst = 1'b0; adj = 1'b0; sel = 1'b0;
    sec_1s_in = 4'd4; sec_10s_in = 4'd3; min_1s_in = 4'd2; min_10s_in = 4'd1;
    repeat (3) @(negedge clk);
    check_out("reset", AB, SB, 1'b1);

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_out("post_reset_blank", AB, SB, 1'b1);

    for (int i = 0; i < tbl.size(); i++) begin
      sec_1s_in = tbl[i].s1; sec_10s_in = tbl[i].s10;
      min_1s_in = tbl[i].m1; min_10s_in = tbl[i].m10;
      adj = tbl[i].adj; sel = tbl[i].sel;
      repeat (tbl[i].ncyc) @(posedge clk);
      @(negedge clk);
      check_out($sformatf("row%0d", i), tbl[i].e_an, tbl[i].e_seg, tbl[i].e_dp);
    end

    // Reset mid-scan while idx2 is lit.
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_out("midscan_reset", AB, SB, 1'b1);
    @(negedge clk);
    sec_1s_in = 4'd4;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_out("rerelease_blank", AB, SB, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check_out("rerelease_idx0", A0, S4, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
